tri_raster: RTL and testbench

TRI_RASTER -- requirements
Module: tri_raster

---
 rtl/tri_raster_pkg.sv | 24 ++
 rtl/tri_raster_edge_eval.sv | 51 +++++
 rtl/tri_raster.sv | 200 ++++++++++++++++++++
 tb/tb_tri_raster.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/tri_raster_pkg.sv
// ============================================================================
// Module : tri_raster_pkg
// Brief  : Shared FSM state encoding and edge-function width helper.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package tri_raster_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SETUP = 2'd2,
    ST_SCAN  = 2'd3
  } state_t;

  // Two (COORD_W+1)-bit signed products plus one bit for their difference.
  function automatic int edge_w(input int coord_w);
    return 2 * coord_w + 3;
  endfunction

endpackage

`default_nettype wire

// File: rtl/tri_raster_edge_eval.sv
// ============================================================================
// Module : tri_edge_eval
// Brief  : One edge function E = (x-xa)*dy - (y-ya)*dx with sign/zero flags.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tri_edge_eval
  import tri_raster_pkg::*;
#(
  parameter int COORD_W = 3
) (
  input  logic [COORD_W-1:0] x_i,
  input  logic [COORD_W-1:0] y_i,
  input  logic [COORD_W-1:0] xa_i,
  input  logic [COORD_W-1:0] ya_i,
  input  logic [COORD_W:0]   dx_i,
  input  logic [COORD_W:0]   dy_i,
  output logic               ge0_o,
  output logic               le0_o,
  output logic               zero_o
);

  localparam int EW = edge_w(COORD_W);

  logic [COORD_W:0] w_rx;
  logic [COORD_W:0] w_ry;
  logic signed [EW-1:0] w_rx_s;
  logic signed [EW-1:0] w_ry_s;
  logic signed [EW-1:0] w_dx_s;
  logic signed [EW-1:0] w_dy_s;
  logic signed [EW-1:0] w_e;

  assign w_rx = {1'b0, x_i} - {1'b0, xa_i};
  assign w_ry = {1'b0, y_i} - {1'b0, ya_i};

  // Sign-extend every operand to full width so nothing is truncated.
  assign w_rx_s = {{(EW-COORD_W-1){w_rx[COORD_W]}}, w_rx};
  assign w_ry_s = {{(EW-COORD_W-1){w_ry[COORD_W]}}, w_ry};
  assign w_dx_s = {{(EW-COORD_W-1){dx_i[COORD_W]}}, dx_i};
  assign w_dy_s = {{(EW-COORD_W-1){dy_i[COORD_W]}}, dy_i};

  assign w_e = (w_rx_s * w_dy_s) - (w_ry_s * w_dx_s);

  assign zero_o = (w_e == '0);
  assign ge0_o  = ~w_e[EW-1];
  assign le0_o  = w_e[EW-1] | zero_o;

endmodule

`default_nettype wire

// File: rtl/tri_raster.sv
// ============================================================================
// Module : tri_raster
// Brief  : Loads three vertices and scans a window row-major, flagging pixels
//          covered by the triangle. TRI_RASTER_BBOX_EN limits the scan window
//          to the vertex bounding box; otherwise the full grid is scanned.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tri_raster
  import tri_raster_pkg::*;
#(
  parameter int COORD_W = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               nt,
  input  logic [COORD_W-1:0] xi,
  input  logic [COORD_W-1:0] yi,
  output logic               busy,
  output logic               ov,
  output logic               po,
  output logic [COORD_W-1:0] xo,
  output logic [COORD_W-1:0] yo
);

  state_t               state_q;
  logic                 ld_sel_q;
  logic [COORD_W-1:0]   vx_q [3];
  logic [COORD_W-1:0]   vy_q [3];
  logic [COORD_W:0]     dx_q [3];
  logic [COORD_W:0]     dy_q [3];
  logic [COORD_W:0]     dx_d [3];
  logic [COORD_W:0]     dy_d [3];
  logic [COORD_W-1:0]   xmin_q, xmax_q, ymin_q, ymax_q;
  logic [COORD_W-1:0]   xmin_d, xmax_d, ymin_d, ymax_d;
  logic [COORD_W-1:0]   sx_q, sy_q;
  logic [COORD_W-1:0]   sx_d, sy_d;
  logic                 busy_q, ov_q, po_q;
  logic [COORD_W-1:0]   xo_q, yo_q;

  logic [2:0]           w_ge0;
  logic [2:0]           w_le0;
  logic [2:0]           w_zero;
  logic                 w_covered;
  logic                 w_row_end;
  logic                 w_last_px;

  // Edge k runs from vertex k to vertex (k+1) mod 3.
  for (genvar k = 0; k < 3; k++) begin : g_edge
    localparam int KB = (k + 1) % 3;

    assign dx_d[k] = {1'b0, vx_q[KB]} - {1'b0, vx_q[k]};
    assign dy_d[k] = {1'b0, vy_q[KB]} - {1'b0, vy_q[k]};

    tri_edge_eval #(
      .COORD_W (COORD_W)
    ) u_edge (
      .x_i    (sx_q),
      .y_i    (sy_q),
      .xa_i   (vx_q[k]),
      .ya_i   (vy_q[k]),
      .dx_i   (dx_q[k]),
      .dy_i   (dy_q[k]),
      .ge0_o  (w_ge0[k]),
      .le0_o  (w_le0[k]),
      .zero_o (w_zero[k])
    );
  end

  // Collinear vertices make the three E sum to zero, so the same-sign test
  // alone restricts degenerate triangles to pixels where every E is zero.
  assign w_covered = (&w_ge0) | (&w_le0) | (&w_zero);

  always_comb begin
`ifdef TRI_RASTER_BBOX_EN
    xmin_d = vx_q[0];
    xmax_d = vx_q[0];
    ymin_d = vy_q[0];
    ymax_d = vy_q[0];
    if (vx_q[1] < xmin_d) xmin_d = vx_q[1];
    if (vx_q[2] < xmin_d) xmin_d = vx_q[2];
    if (vx_q[1] > xmax_d) xmax_d = vx_q[1];
    if (vx_q[2] > xmax_d) xmax_d = vx_q[2];
    if (vy_q[1] < ymin_d) ymin_d = vy_q[1];
    if (vy_q[2] < ymin_d) ymin_d = vy_q[2];
    if (vy_q[1] > ymax_d) ymax_d = vy_q[1];
    if (vy_q[2] > ymax_d) ymax_d = vy_q[2];
`else
    xmin_d = '0;
    xmax_d = '1;
    ymin_d = '0;
    ymax_d = '1;
`endif
  end

  assign w_row_end = (sx_q == xmax_q);
  assign w_last_px = w_row_end && (sy_q == ymax_q);

  always_comb begin
    sx_d = sx_q + 1'b1;
    sy_d = sy_q;
    if (w_row_end) begin
      sx_d = xmin_q;
      sy_d = sy_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      ld_sel_q <= 1'b0;
      for (int k = 0; k < 3; k++) begin
        vx_q[k] <= '0;
        vy_q[k] <= '0;
        dx_q[k] <= '0;
        dy_q[k] <= '0;
      end
      xmin_q <= '0;
      xmax_q <= '0;
      ymin_q <= '0;
      ymax_q <= '0;
      sx_q   <= '0;
      sy_q   <= '0;
      busy_q <= 1'b0;
      ov_q   <= 1'b0;
      po_q   <= 1'b0;
      xo_q   <= '0;
      yo_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          busy_q <= nt;
          ov_q   <= 1'b0;
          po_q   <= 1'b0;
          if (nt) begin
            vx_q[0]  <= xi;
            vy_q[0]  <= yi;
            ld_sel_q <= 1'b0;
            state_q  <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          busy_q <= 1'b1;
          ov_q   <= 1'b0;
          po_q   <= 1'b0;
          if (!ld_sel_q) begin
            vx_q[1]  <= xi;
            vy_q[1]  <= yi;
            ld_sel_q <= 1'b1;
          end else begin
            vx_q[2] <= xi;
            vy_q[2] <= yi;
            state_q <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          busy_q  <= 1'b1;
          ov_q    <= 1'b0;
          po_q    <= 1'b0;
          dx_q    <= dx_d;
          dy_q    <= dy_d;
          xmin_q  <= xmin_d;
          xmax_q  <= xmax_d;
          ymin_q  <= ymin_d;
          ymax_q  <= ymax_d;
          sx_q    <= xmin_d;
          sy_q    <= ymin_d;
          state_q <= ST_SCAN;
        end
        ST_SCAN: begin
          // busy stays high here so it covers the cycle showing the last pixel.
          busy_q <= 1'b1;
          ov_q   <= 1'b1;
          po_q   <= w_covered;
          xo_q   <= sx_q;
          yo_q   <= sy_q;
          if (w_last_px) begin
            state_q <= ST_IDLE;
          end else begin
            sx_q <= sx_d;
            sy_q <= sy_d;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign ov   = ov_q;
  assign po   = po_q;
  assign xo   = xo_q;
  assign yo   = yo_q;

endmodule

`default_nettype wire

// File: tb/tb_tri_raster.sv
// Self-checking bench for tri_raster: directed triangles plus random ones
// compared pixel-by-pixel against a plain-arithmetic coverage model.
`default_nettype none

module tb_tri_raster;

  localparam int CW = 3;
  localparam int N  = 1 << CW;
`ifdef TRI_RASTER_BBOX_EN
  localparam int R027_OV = 25;
  localparam int R030_OV = 1;
`else
  localparam int R027_OV = 64;
  localparam int R030_OV = 64;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          nt;
  logic [CW-1:0] xi, yi;
  logic          busy, ov, po;
  logic [CW-1:0] xo, yo;

  always #5 clk = ~clk;

  tri_raster #(.COORD_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .nt    (nt),
    .xi    (xi),
    .yi    (yi),
    .busy  (busy),
    .ov    (ov),
    .po    (po),
    .xo    (xo),
    .yo    (yo)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  typedef struct {int x; int y; int p;} pix_t;
  pix_t exp_q[$];

  // Signed doubled area of (a, b, p): which side of line a->b the point is on.
  function automatic int side(int ax, int ay, int bx, int by, int px, int py);
    return (px - ax) * (by - ay) - (py - ay) * (bx - ax);
  endfunction

  function automatic void build_model(int x0, int y0, int x1, int y1, int x2, int y2);
    int lox, hix, loy, hiy, s0, s1, s2;
    pix_t e;
    exp_q.delete();
`ifdef TRI_RASTER_BBOX_EN
    lox = (x0 < x1) ? x0 : x1; lox = (x2 < lox) ? x2 : lox;
    hix = (x0 > x1) ? x0 : x1; hix = (x2 > hix) ? x2 : hix;
    loy = (y0 < y1) ? y0 : y1; loy = (y2 < loy) ? y2 : loy;
    hiy = (y0 > y1) ? y0 : y1; hiy = (y2 > hiy) ? y2 : hiy;
`else
    lox = 0; hix = N - 1; loy = 0; hiy = N - 1;
`endif
    for (int y = loy; y <= hiy; y++) begin
      for (int x = lox; x <= hix; x++) begin
        s0 = side(x0, y0, x1, y1, x, y);
        s1 = side(x1, y1, x2, y2, x, y);
        s2 = side(x2, y2, x0, y0, x, y);
        e.x = x; e.y = y;
        e.p = ((s0 >= 0 && s1 >= 0 && s2 >= 0) || (s0 <= 0 && s1 <= 0 && s2 <= 0)) ? 1 : 0;
        exp_q.push_back(e);
      end
    end
  endfunction

  // Caller is positioned just after a falling edge with the DUT idle.
  task automatic run_tri(input int x0, input int y0, input int x1, input int y1,
                         input int x2, input int y2, input bit poke,
                         output int n_ov, output int n_po);
    pix_t e;
    int span, stray;
    bit seen, done, prev_ov;
    build_model(x0, y0, x1, y1, x2, y2);
    nt = 1'b1; xi = CW'(x0); yi = CW'(y0);
    @(negedge clk);
    check("busy_after_nt", int'(busy), 1);
    nt = 1'b0; xi = CW'(x1); yi = CW'(y1);
    @(negedge clk);
    xi = CW'(x2); yi = CW'(y2);
    n_ov = 0; n_po = 0; span = 0; stray = 0;
    seen = 1'b0; done = 1'b0; prev_ov = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      if (poke) begin
        if (n_ov == 3) begin
          nt = 1'b1; xi = CW'($urandom); yi = CW'($urandom);
        end else begin
          nt = 1'b0;
        end
      end
      if (ov) begin
        n_ov++;
        if (po) n_po++;
        if (exp_q.size() == 0) begin
          check("extra_pixel", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("xo", int'(xo), e.x);
          check("yo", int'(yo), e.y);
          check("po", int'(po), e.p);
        end
      end else if (po) begin
        stray++;
      end
      if (ov || seen) begin
        seen = 1'b1;
        if (busy) span++;
      end
      if (!busy) begin
        done = 1'b1;
        check("busy_drop_after_last", int'(prev_ov), 1);
      end
      prev_ov = ov;
    end
    nt = 1'b0;
    if (!done) check("timeout", 0, 1);
    check("pixels_left", exp_q.size(), 0);
    check("ov_contiguous", n_ov, span);
    check("po_without_ov", stray, 0);
  endtask

  int n_ov, n_po;
  int rv[6];
  bit got_ov;

  initial begin
    reset = 1'b1; nt = 1'b0; xi = '0; yi = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_ov", int'(ov), 0);
    check("rst_po", int'(po), 0);
    check("rst_xo", int'(xo), 0);
    check("rst_yo", int'(yo), 0);
    reset = 1'b0;

    run_tri(1, 1, 5, 1, 1, 5, 1'b0, n_ov, n_po);
    check("r027_ov", n_ov, R027_OV);
    check("r027_po", n_po, 15);

    run_tri(1, 1, 1, 5, 5, 1, 1'b0, n_ov, n_po);
    check("r028_po", n_po, 15);

    run_tri(0, 0, 7, 7, 3, 3, 1'b0, n_ov, n_po);
    check("r029_po", n_po, 8);

    run_tri(4, 2, 4, 2, 4, 2, 1'b0, n_ov, n_po);
    check("r030_ov", n_ov, R030_OV);
    check("r030_po", n_po, R030_OV);

    run_tri(1, 1, 5, 1, 1, 5, 1'b1, n_ov, n_po);
    check("nt_ignored_ov", n_ov, R027_OV);
    check("nt_ignored_po", n_po, 15);

    // Reset in the middle of a scan, then a new triangle right after release.
    nt = 1'b1; xi = 3'd0; yi = 3'd0;
    @(negedge clk); nt = 1'b0; xi = 3'd7; yi = 3'd0;
    @(negedge clk); xi = 3'd0; yi = 3'd7;
    got_ov = 1'b0;
    for (int c = 0; c < 20 && !got_ov; c++) begin
      @(negedge clk);
      if (ov) got_ov = 1'b1;
    end
    check("mid_scan_reached", int'(got_ov), 1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_busy", int'(busy), 0);
    check("midrst_ov", int'(ov), 0);
    check("midrst_po", int'(po), 0);
    check("midrst_xo", int'(xo), 0);
    check("midrst_yo", int'(yo), 0);
    reset = 1'b0;
    run_tri(7, 0, 0, 7, 7, 7, 1'b0, n_ov, n_po);
    check("after_rst_po", n_po, 36);

    for (int t = 0; t < 12; t++) begin
      for (int i = 0; i < 6; i++) rv[i] = int'($urandom_range(0, N - 1));
      run_tri(rv[0], rv[1], rv[2], rv[3], rv[4], rv[5], (t % 3) == 0, n_ov, n_po);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
